// File: rtl/uart_tx_serializer_if.sv
// Byte handoff channel between upstream logic and the UART transmit serializer.
// Ports (signals):
//   tx_data  - byte to send, sampled when tx_valid && tx_ready at a clk edge
//   tx_valid - upstream has a byte ready
//   tx_ready - serializer can accept a byte
// Modports: master (upstream producer), slave (serializer).
interface uart_tx_serializer_if #(
  parameter int unsigned DATA_BITS = 32'd8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer. Uses the baud divider's square wave as a bit-time
// reference (synchronized, rising-edge detected) and shifts one byte per frame
// onto txd: start bit, LSB-first data, optional parity, one or two stop bits.
// Ports:
//   clk     - system clock
//   res     - asynchronous active-high reset
//   baud_in - divider square wave, treated as data
//   up      - byte handoff channel (slave side: tx_data, tx_valid, tx_ready)
//   txd     - serial line, idles high
//   busy    - a frame is pending or in progress
module uart_tx_serializer #(
  parameter int unsigned DATA_BITS = 32'd8,
  parameter int unsigned PARITY    = 32'd0,
  parameter int unsigned STOP_BITS = 32'd1
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 baud_in,
  uart_tx_serializer_if.slave  up,
  output logic                 txd,
  output logic                 busy
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 32'd1);
  // Value of stop_cnt_r on the tick that ends the last stop bit.
  localparam logic       STOP_LAST = (STOP_BITS == 32'd2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    PAR   = 3'd4,
    STOP  = 3'd5
  } state_t;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == 32'd2) ? ~(^d) : (^d);
  endfunction

  logic                 baud_meta_r, baud_sync_r, baud_prev_r;
  logic                 tick_s, accept_s;
  state_t               state_r, state_nxt_s;
  logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
  logic [2:0]           bit_cnt_r, bit_cnt_nxt_s;
  logic                 stop_cnt_r, stop_cnt_nxt_s;
  logic                 parity_r, parity_nxt_s;
  logic                 txd_r, txd_nxt_s;
  logic                 tx_ready_r;
  logic                 busy_r;

  assign tick_s   = baud_sync_r & ~baud_prev_r;
  assign accept_s = up.tx_valid & tx_ready_r;

  assign txd         = txd_r;
  assign busy        = busy_r;
  assign up.tx_ready = tx_ready_r;

  // Two-flop synchronizer plus edge-detect flop for the baud reference.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      baud_meta_r <= 1'b0;
      baud_sync_r <= 1'b0;
      baud_prev_r <= 1'b0;
    end else begin
      baud_meta_r <= baud_in;
      baud_sync_r <= baud_meta_r;
      baud_prev_r <= baud_sync_r;
    end
  end

  // Next-state, datapath and next txd value for the frame sequencer.
  always_comb begin
    state_nxt_s    = state_r;
    shift_nxt_s    = shift_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    stop_cnt_nxt_s = stop_cnt_r;
    parity_nxt_s   = parity_r;
    txd_nxt_s      = txd_r;
    case (state_r)
      IDLE: begin
        txd_nxt_s = 1'b1;
        // Ticks are ignored here; a tick coinciding with accept is not consumed.
        if (accept_s) begin
          shift_nxt_s  = up.tx_data;
          parity_nxt_s = calc_parity(up.tx_data);
          state_nxt_s  = ARM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARM: begin
        if (tick_s) begin
          txd_nxt_s   = 1'b0;
          state_nxt_s = START;
        end else begin
          txd_nxt_s = 1'b1;
        end
      end
      START: begin
        if (tick_s) begin
          txd_nxt_s     = shift_r[0];
          bit_cnt_nxt_s = 3'd0;
          state_nxt_s   = DATA;
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          if (bit_cnt_r < LAST_BIT) begin
            shift_nxt_s   = {1'b0, shift_r[DATA_BITS-1:1]};
            txd_nxt_s     = shift_r[1];
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          end else if (PARITY != 32'd0) begin
            txd_nxt_s   = parity_r;
            state_nxt_s = PAR;
          end else begin
            txd_nxt_s      = 1'b1;
            stop_cnt_nxt_s = 1'b0;
            state_nxt_s    = STOP;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      PAR: begin
        if (tick_s) begin
          txd_nxt_s      = 1'b1;
          stop_cnt_nxt_s = 1'b0;
          state_nxt_s    = STOP;
        end else begin
          state_nxt_s = PAR;
        end
      end
      STOP: begin
        txd_nxt_s = 1'b1;
        if (tick_s) begin
          if (stop_cnt_r == STOP_LAST) begin
            state_nxt_s = IDLE;
          end else begin
            stop_cnt_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: begin
        txd_nxt_s   = 1'b1;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; ready/busy follow the next state.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      bit_cnt_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      parity_r   <= 1'b0;
      txd_r      <= 1'b1;
      tx_ready_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      shift_r    <= shift_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      stop_cnt_r <= stop_cnt_nxt_s;
      parity_r   <= parity_nxt_s;
      txd_r      <= txd_nxt_s;
      tx_ready_r <= (state_nxt_s == IDLE);
      busy_r     <= (state_nxt_s != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: three configurations (8N1, 8O2,
// 8E1) share one clock, reset and a 20-clk baud square wave. Expected frames
// come from a bit-list model built from the byte value.
module tb_uart_tx_serializer;

  logic clk     = 1'b0;
  logic res     = 1'b1;
  logic baud_in = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   hs_cnt  = 0;
  int   last_wait;
  bit   exp_q[$];
  int   par_of [3] = '{0, 2, 1};
  int   stop_of[3] = '{1, 2, 1};

  logic txd0, txd1, txd2, busy0, busy1, busy2;

  uart_tx_serializer_if #(.DATA_BITS(8)) if0 ();
  uart_tx_serializer_if #(.DATA_BITS(8)) if1 ();
  uart_tx_serializer_if #(.DATA_BITS(8)) if2 ();

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .res(res), .baud_in(baud_in), .up(if0), .txd(txd0), .busy(busy0));
  uart_tx_serializer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_8o2 (
    .clk(clk), .res(res), .baud_in(baud_in), .up(if1), .txd(txd1), .busy(busy1));
  uart_tx_serializer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .res(res), .baud_in(baud_in), .up(if2), .txd(txd2), .busy(busy2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (if0.tx_valid && if0.tx_ready) hs_cnt <= hs_cnt + 1;

  initial begin
    forever begin
      repeat (10) @(negedge clk);
      baud_in = ~baud_in;
    end
  end

  function automatic logic txd_of(input int which);
    case (which)
      0: return txd0;
      1: return txd1;
      default: return txd2;
    endcase
  endfunction

  function automatic logic ready_of(input int which);
    case (which)
      0: return if0.tx_ready;
      1: return if1.tx_ready;
      default: return if2.tx_ready;
    endcase
  endfunction

  function automatic logic busy_of(input int which);
    case (which)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_drv(input int which, input logic [7:0] d, input logic v);
    case (which)
      0: begin if0.tx_data = d; if0.tx_valid = v; end
      1: begin if1.tx_data = d; if1.tx_valid = v; end
      default: begin if2.tx_data = d; if2.tx_valid = v; end
    endcase
  endtask

  // Reference frame: start 0, data LSB first, parity from the ones count, stop 1s.
  task automatic build_frame(input logic [7:0] d, input int par, input int stops);
    int ones;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    ones = $countones(d);
    if (par == 1) exp_q.push_back((ones % 2) == 1);
    if (par == 2) exp_q.push_back((ones % 2) == 0);
    for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
  endtask

  task automatic send(input int which, input logic [7:0] d);
    int n = 0;
    while (ready_of(which) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    set_drv(which, d, 1'b1);
    @(posedge clk);
    #1 set_drv(which, d, 1'b0);
  endtask

  // Waits for the start edge, then checks each bit at its first and last cycle.
  task automatic check_frame(input int which, input logic [7:0] d, input string tag,
                             output int t_start);
    int n = 0;
    build_frame(d, par_of[which], stop_of[which]);
    while (txd_of(which) !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    t_start   = cyc;
    chk($sformatf("%s_start_seen", tag), {31'd0, txd_of(which)}, 32'd0);
    if (txd_of(which) !== 1'b0) return;
    chk($sformatf("%s_busy_in_frame", tag), {31'd0, busy_of(which)}, 32'd1);
    for (int b = 0; b < exp_q.size(); b++) begin
      chk($sformatf("%s_bit%0d_head", tag, b), {31'd0, txd_of(which)}, {31'd0, exp_q[b]});
      repeat (19) @(negedge clk);
      chk($sformatf("%s_bit%0d_tail", tag, b), {31'd0, txd_of(which)}, {31'd0, exp_q[b]});
      @(negedge clk);
    end
    chk($sformatf("%s_ready_after", tag), {31'd0, ready_of(which)}, 32'd1);
    chk($sformatf("%s_busy_after", tag), {31'd0, busy_of(which)}, 32'd0);
  endtask

  initial begin
    int          t, t_acc, n, base, gap;
    logic [7:0]  d;
    bit          hi;

    for (int w = 0; w < 3; w++) set_drv(w, 8'h00, 1'b0);

    // Reset defaults
    repeat (5) @(negedge clk);
    chk("rst_txd", {31'd0, txd0}, 32'd1);
    chk("rst_ready", {31'd0, if0.tx_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_ready_8o2", {31'd0, if1.tx_ready}, 32'd0);
    res = 1'b0;
    #1 chk("rel_ready_before_edge", {31'd0, if0.tx_ready}, 32'd0);
    @(negedge clk);
    chk("rel_ready", {31'd0, if0.tx_ready}, 32'd1);
    chk("rel_busy", {31'd0, busy0}, 32'd0);
    chk("rel_txd", {31'd0, txd0}, 32'd1);

    // Basic 8N1 frame
    send(0, 8'hA5);
    check_frame(0, 8'hA5, "8n1_a5", t);

    // Odd parity, two stop bits; then even parity
    send(1, 8'h03);
    check_frame(1, 8'h03, "8o2_03", t);
    send(2, 8'h03);
    check_frame(2, 8'h03, "8e1_03", t);

    // Back-to-back with tx_valid held
    base = hs_cnt;
    set_drv(0, 8'h55, 1'b1);
    n = 0;
    while (hs_cnt == base && n < 100) begin
      @(negedge clk);
      n++;
    end
    set_drv(0, 8'hFF, 1'b1);
    check_frame(0, 8'h55, "b2b_first", t);
    n = 0;
    while (hs_cnt != base + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    set_drv(0, 8'hFF, 1'b0);
    check_frame(0, 8'hFF, "b2b_second", t);
    gap = n + last_wait;
    chk("b2b_gap_ge_20", {31'd0, gap >= 20}, 32'd1);
    repeat (60) @(negedge clk);
    chk("b2b_handshakes", hs_cnt - base, 32'd2);

    // Accept landing in a tick cycle: start must wait for the next tick
    @(posedge baud_in);
    @(posedge clk);
    @(posedge clk);
    #1 set_drv(0, 8'h3C, 1'b1);
    @(posedge clk);
    #1 set_drv(0, 8'h3C, 1'b0);
    t_acc = cyc;
    check_frame(0, 8'h3C, "acc_tick", t);
    chk("acc_tick_start_delay", t - t_acc, 32'd20);

    // Randomized frames on every configuration
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 3; w++) begin
        d = 8'($urandom_range(0, 255));
        send(w, d);
        check_frame(w, d, $sformatf("rand_c%0d_r%0d", w, r), t);
      end
    end

    // Reset in the middle of data bit 3 (bit 3 forced low so the abort shows)
    d = 8'($urandom_range(0, 255)) & 8'hF7;
    send(0, d);
    n = 0;
    while (txd0 !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (90) @(negedge clk);
    chk("mid_bit3_on_line", {31'd0, txd0}, 32'd0);
    res = 1'b1;
    #1 chk("mid_async_txd", {31'd0, txd0}, 32'd1);
    repeat (3) @(negedge clk);
    res = 1'b0;
    hi = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (txd0 !== 1'b1) hi = 1'b0;
    end
    chk("mid_no_resume", {31'd0, hi}, 32'd1);
    send(0, 8'h0F);
    check_frame(0, 8'h0F, "post_rst_0f", t);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Serial transmit stage downstream of the baud-rate divider. Consumes the divider's square-wave output as a bit-time reference and shifts one byte per frame onto `txd` in UART format: start bit, LSB-first data, optional parity, stop bit(s). Upstream logic hands over bytes through a valid/ready handshake.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5..8.
- `PARITY`, default 0: parity mode. 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: stop bits per frame, legal values 1 or 2.
- `clk` input, 1 bit: system clock, 48 MHz. Single clock domain.
- `res` input, 1 bit: reset. Asynchronous, active-high.
- `baud_in` input, 1 bit: divider output square wave. Treated as data and never used as a clock.
- `tx_data` input, `DATA_BITS` bits: byte to send. Sampled on accept.
- `tx_valid` input, 1 bit: upstream has a byte ready.
- `tx_ready` output, 1 bit: block can accept a byte.
- `txd` output, 1 bit: serial line. Idles high.
- `busy` output, 1 bit: a frame is pending or in progress.

## Operation
- **Tick generation.** `baud_in` passes through a 2-flop synchronizer, then a third flop for edge detection.
  - `tick` is one `clk` cycle wide, on each synchronized rising edge only.
  - One bit time equals the interval between ticks.
- **Accept.** A handshake occurs when `tx_valid && tx_ready` is true at a `clk` edge.
  - `tx_data` is latched into the shift register.
  - Parity is computed from `tx_data` at accept: even = XOR of data bits; odd = inverted XOR.
  - `tx_ready` drops on the next cycle.
- **FSM states:** IDLE, ARM, START, DATA, PAR, STOP.
  - IDLE: `txd`=1, `tx_ready`=1, `busy`=0. Accept moves to ARM.
  - ARM: `txd`=1. On `tick`, drive `txd`=0 and go to START. This aligns frames to the bit clock.
  - START: on `tick`, drive data bit 0, set `bit_cnt`=0, go to DATA.
  - DATA: on `tick`:
    - if `bit_cnt` < `DATA_BITS`-1: shift right, drive the next bit, increment `bit_cnt`.
    - else if `PARITY`≠0: drive the parity bit and go to PAR.
    - else: drive `txd`=1 and go to STOP.
  - PAR: on `tick`, drive `txd`=1 and go to STOP.
  - STOP: counts `STOP_BITS` ticks with `txd`=1. On the final tick go to IDLE; `tx_ready`=1 from the next cycle.
- **Data width.** `bit_cnt` is 3 bits and never wraps, because it is compared against `DATA_BITS`-1 ≤ 7.
- **Ticks outside a frame.** A `tick` in IDLE is ignored.
- **Simultaneous accept and tick** in the same cycle: the tick is not consumed. ARM waits for the following tick.
- **Upstream data changes.** `tx_valid` held or `tx_data` changed during a frame has no effect until IDLE.
- **Reset mid-frame.** The frame is aborted. `txd` goes to 1 asynchronously, the FSM goes to IDLE, and the latched byte is discarded. No partial retransmission after release.

## Timing
- **Reset values:** `txd`=1, `tx_ready`=0, `busy`=0.
  - Synchronizer flops reset to 0.
  - FSM resets to IDLE.
  - Shift register, `bit_cnt` and parity reset to 0.
- **After reset release:** `tx_ready` rises at the first `clk` edge after `res` deasserts.
- **Tick latency.** `tick` is high in the cycle after the 2nd `clk` edge that samples `baud_in`=1.
- **`txd` latency.** All outputs are registered. A `txd` transition appears at the 3rd `clk` edge after the first edge sampling `baud_in` high.
- **Frame length** = 1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS` bit times.
  - Plus 0..1 bit time of ARM wait before the frame.
  - Each bit holds for exactly one `baud_in` period, ±1 `clk` of synchronizer jitter.
- **`busy`** is 1 from the cycle after accept until the cycle `tx_ready` returns to 1.
- **Back-to-back throughput.** Minimum idle between frames is the ARM wait: stop end to next start edge is at least 1 bit time.

## Test plan
- **Reset defaults.** Assert `res` for 5 cycles, then release.
  - Required: `txd`=1 and `tx_ready`=0 during reset.
  - Required: `tx_ready`=1 one cycle after release; `busy`=0.
- **Basic 8N1 frame.** `baud_in` period 20 `clk`, defaults, send 0xA5.
  - Required `txd` sequence: 0,1,0,1,0,0,1,0,1,1, each bit 20 cycles.
  - Required: `tx_ready` returns after the stop bit.
- **Parity, two stop bits.** `PARITY`=2, `STOP_BITS`=2, send 0x03.
  - Required frame: start 0; data 1,1,0,0,0,0,0,0; parity 1 (odd); stop 1,1.
  - `PARITY`=1 with 0x03 must give parity 0.
- **Back-to-back.** Hold `tx_valid`=1 with 0x55, then 0xFF.
  - Required: two complete frames with at least one 20-cycle high gap between them.
  - Required: exactly two handshakes observed.
- **Accept on tick cycle.** Raise `tx_valid` so the accept lands in a `tick` cycle.
  - Required: the start bit begins on the next tick, 20 cycles later, not the current one.
- **Reset mid-frame.** Assert `res` while data bit 3 is on the line.
  - Required: `txd`=1 within the same cycle (asynchronous) and no remaining bits sent.
  - Required: a subsequent 0x0F transmits a clean, correct frame.
